// File: rtl/booth_mult_arbiter.sv
// Two-requester round-robin front end for an iterative radix-2 Booth multiplier.
// IDLE accepts one operand pair, ITER runs WIDTH Booth steps plus a result transfer, DONE holds the product.
module booth_mult_arbiter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [WIDTH-1:0]   req0_a,
  input  logic [WIDTH-1:0]   req0_b,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [WIDTH-1:0]   req1_a,
  input  logic [WIDTH-1:0]   req1_b,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic               resp_id,
  output logic [2*WIDTH-1:0] resp_product,
  output logic               busy
);

  localparam int unsigned AW = WIDTH + 1;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, ITER, DONE} state_e;

  state_e             state_q, state_d;
  logic [AW-1:0]      acc_q, acc_d;
  logic [AW-1:0]      mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic               qm1_q, qm1_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               last_q, last_d;
  logic               id_q, id_d;
  logic               resp_valid_q, resp_valid_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic               busy_q, busy_d;
  logic               grant_c;
  logic               accept_c;
  logic [AW-1:0]      sum_c;

  // On a tie the requester not granted last wins; otherwise the sole valid one.
  assign grant_c    = (req0_valid && req1_valid) ? ~last_q : req1_valid;
  assign req0_ready = reset && (state_q == IDLE) && req0_valid && !grant_c;
  assign req1_ready = reset && (state_q == IDLE) && req1_valid && grant_c;
  assign accept_c   = req0_ready || req1_ready;

  // Booth recoding of {Q[0], q_-1}: 01 adds M, 10 subtracts M.
  always_comb begin
    unique case ({mplier_q[0], qm1_q})
      2'b01:   sum_c = acc_q + mcand_q;
      2'b10:   sum_c = acc_q - mcand_q;
      default: sum_c = acc_q;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    mcand_d      = mcand_q;
    mplier_d     = mplier_q;
    qm1_d        = qm1_q;
    cnt_d        = cnt_q;
    last_d       = last_q;
    id_d         = id_q;
    resp_valid_d = resp_valid_q;
    prod_d       = prod_q;
    unique case (state_q)
      IDLE: begin
        if (accept_c) begin
          id_d     = grant_c;
          last_d   = grant_c;
          mcand_d  = grant_c ? {req1_a[WIDTH-1], req1_a} : {req0_a[WIDTH-1], req0_a};
          mplier_d = grant_c ? req1_b : req0_b;
          acc_d    = '0;
          qm1_d    = 1'b0;
          cnt_d    = '0;
          state_d  = ITER;
        end
      end
      ITER: begin
        if (cnt_q == CW'(WIDTH)) begin
          prod_d       = {acc_q[WIDTH-1:0], mplier_q};
          resp_valid_d = 1'b1;
          state_d      = DONE;
        end else begin
          acc_d    = {sum_c[AW-1], sum_c[AW-1:1]};
          mplier_d = {sum_c[0], mplier_q[WIDTH-1:1]};
          qm1_d    = mplier_q[0];
          cnt_d    = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      acc_q        <= '0;
      mcand_q      <= '0;
      mplier_q     <= '0;
      qm1_q        <= 1'b0;
      cnt_q        <= '0;
      last_q       <= 1'b1;
      id_q         <= 1'b0;
      resp_valid_q <= 1'b0;
      prod_q       <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      mcand_q      <= mcand_d;
      mplier_q     <= mplier_d;
      qm1_q        <= qm1_d;
      cnt_q        <= cnt_d;
      last_q       <= last_d;
      id_q         <= id_d;
      resp_valid_q <= resp_valid_d;
      prod_q       <= prod_d;
      busy_q       <= busy_d;
    end
  end

  assign resp_valid   = resp_valid_q;
  assign resp_id      = id_q;
  assign resp_product = prod_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_booth_mult_arbiter.sv
// Directed and randomized checks of booth_mult_arbiter against a transaction-level reference model.
module tb_booth_mult_arbiter;

  localparam int unsigned W = 32;
  localparam int LAT = W + 1;

  logic           clk = 1'b0;
  logic           reset;
  logic           req0_valid, req1_valid;
  logic           req0_ready, req1_ready;
  logic [W-1:0]   req0_a, req0_b, req1_a, req1_b;
  logic           resp_valid, resp_ready, resp_id;
  logic [2*W-1:0] resp_product;
  logic           busy;

  int checks = 0;
  int errors = 0;

  booth_mult_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_product(resp_product), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    longint x, y;
    x = $signed(a);
    y = $signed(b);
    return 64'(x * y);
  endfunction

  function automatic logic [W-1:0] rnd_op();
    case ($urandom_range(0, 7))
      0:       return 32'h8000_0000;
      1:       return 32'h7FFF_FFFF;
      2:       return 32'h0;
      3:       return 32'hFFFF_FFFF;
      default: return $urandom();
    endcase
  endfunction

  task automatic do_reset();
    reset = 1'b0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    resp_ready = 1'b1;
    #1;
    chk("rst_ready0", 64'(req0_ready), 64'd0);
    chk("rst_ready1", 64'(req1_ready), 64'd0);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_product", resp_product, 64'd0);
    chk("rst_id", 64'(resp_id), 64'd0);
    tick();
    tick();
    reset = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  // Present requests, check the grant, clock the accept edge, then withdraw both valids.
  task automatic issue(input logic v0, input logic v1,
                       input logic [W-1:0] a0, input logic [W-1:0] b0,
                       input logic [W-1:0] a1, input logic [W-1:0] b1, input int g);
    req0_valid = v0; req1_valid = v1;
    req0_a = a0; req0_b = b0; req1_a = a1; req1_b = b1;
    #1;
    chk("grant_ready0", 64'(req0_ready), 64'(v0 && g == 0));
    chk("grant_ready1", 64'(req1_ready), 64'(v1 && g == 1));
    tick();
    chk("busy_after_accept", 64'(busy), 64'd1);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic wait_resp(input logic exp_id, input logic [63:0] exp_prod);
    int lat = 0;
    while (!resp_valid && lat < 200) begin
      tick();
      lat++;
    end
    chk("latency", 64'(lat), 64'(LAT));
    chk("resp_product", resp_product, exp_prod);
    chk("resp_id", 64'(resp_id), 64'(exp_id));
  endtask

  task automatic handshake();
    resp_ready = 1'b1;
    tick();
    chk("post_hs_valid", 64'(resp_valid), 64'd0);
    chk("post_hs_busy", 64'(busy), 64'd0);
  endtask

  logic [W-1:0] pa [2];
  logic [W-1:0] pb [2];
  bit           have [2];
  int           starve [2];

  initial begin
    bit   m_busy, m_last, m_id, ev, e0, e1, v_s [2];
    int   m_cyc, g, done_ops, cyc, hi_cnt;
    logic [63:0] m_prod;

    reset = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0; resp_ready = 1'b1;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;

    // Single requester -5 * 5
    do_reset();
    tick();
    issue(1, 0, 32'hFFFF_FFFB, 32'd5, 0, 0, 0);
    wait_resp(0, 64'hFFFF_FFFF_FFFF_FFE7);
    handshake();

    // Ties from reset: req0 first, then req1, then req0 again
    do_reset();
    issue(1, 1, 32'd5, 32'd10, 32'hFFFF_FFFB, 32'hFFFF_FFEC, 0);
    req1_valid = 1'b1;
    #1;
    chk("no_accept_in_iter", 64'(req1_ready), 64'd0);
    wait_resp(0, 64'd50);
    chk("no_accept_in_done", 64'(req1_ready), 64'd0);
    handshake();
    issue(0, 1, 0, 0, 32'hFFFF_FFFB, 32'hFFFF_FFEC, 1);
    wait_resp(1, 64'd100);
    handshake();
    issue(1, 1, 32'd7, 32'd8, 32'd9, 32'd9, 0);
    wait_resp(0, 64'd56);
    handshake();

    // Corner operands
    issue(0, 1, 0, 0, 32'h8000_0000, 32'h8000_0000, 1);
    wait_resp(1, 64'h4000_0000_0000_0000);
    handshake();
    issue(1, 0, 32'h7FFF_FFFF, 32'h8000_0000, 0, 0, 0);
    wait_resp(0, 64'hC000_0000_8000_0000);
    handshake();
    issue(0, 1, 0, 0, 32'd0, 32'd0, 1);
    wait_resp(1, 64'd0);
    handshake();
    issue(1, 0, 32'd1, 32'd50, 0, 0, 0);
    wait_resp(0, 64'd50);
    handshake();

    // Backpressure: hold the result for 10 cycles with both requesters waiting
    resp_ready = 1'b0;
    issue(0, 1, 0, 0, 32'd20, 32'd30, 1);
    wait_resp(1, 64'd600);
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_valid", 64'(resp_valid), 64'd1);
      chk("bp_product", resp_product, 64'd600);
      chk("bp_id", 64'(resp_id), 64'd1);
      chk("bp_ready0", 64'(req0_ready), 64'd0);
      chk("bp_ready1", 64'(req1_ready), 64'd0);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    handshake();

    // Reset during the 10th iteration aborts the operation
    issue(1, 0, 32'd30, 32'hFFFF_FFE2, 0, 0, 0);
    for (int i = 0; i < 9; i++) tick();
    do_reset();
    hi_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (resp_valid) hi_cnt++;
    end
    chk("abort_no_resp", 64'(hi_cnt), 64'd0);
    issue(1, 0, 32'd100, 32'd100, 0, 0, 0);
    wait_resp(0, 64'd10000);
    handshake();

    // Randomized traffic against the transaction model
    do_reset();
    m_busy = 0; m_last = 1; m_id = 0; m_cyc = 0; m_prod = '0;
    done_ops = 0; cyc = 0;
    have[0] = 0; have[1] = 0; starve[0] = 0; starve[1] = 0;
    while (done_ops < 1000 && cyc < 60000) begin
      for (int n = 0; n < 2; n++) begin
        if (!have[n] && $urandom_range(0, 3) != 0) begin
          have[n] = 1;
          pa[n] = rnd_op();
          pb[n] = rnd_op();
        end
        v_s[n] = have[n] && ($urandom_range(0, 3) != 0);
      end
      req0_valid = v_s[0]; req1_valid = v_s[1];
      req0_a = pa[0]; req0_b = pb[0]; req1_a = pa[1]; req1_b = pb[1];
      resp_ready = ($urandom_range(0, 3) != 0);
      #1;
      g  = (v_s[0] && v_s[1]) ? int'(!m_last) : int'(v_s[1]);
      e0 = !m_busy && v_s[0] && g == 0;
      e1 = !m_busy && v_s[1] && g == 1;
      ev = m_busy && m_cyc >= LAT;
      chk("rnd_ready0", 64'(req0_ready), 64'(e0));
      chk("rnd_ready1", 64'(req1_ready), 64'(e1));
      chk("rnd_resp_valid", 64'(resp_valid), 64'(ev));
      chk("rnd_busy", 64'(busy), 64'(m_busy));
      if (ev) begin
        chk("rnd_id", 64'(resp_id), 64'(m_id));
        chk("rnd_product", resp_product, m_prod);
      end
      if (e0 || e1) begin
        m_busy = 1; m_cyc = 0; m_id = (g == 1); m_last = (g == 1);
        m_prod = ref_mul(pa[g], pb[g]);
        have[g] = 0;
        starve[g] = 0;
        if (v_s[1-g]) starve[1-g]++;
        chk("rnd_starvation", 64'(starve[1-g] <= 1), 64'd1);
      end else if (m_busy) begin
        if (ev && resp_ready) begin
          m_busy = 0;
          done_ops++;
        end else begin
          m_cyc++;
        end
      end
      tick();
      cyc++;
    end
    chk("rnd_ops_done", 64'(done_ops), 64'd1000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/booth_mult_arbiter.md
BOOTH_MULT_ARBITER -- requirements
Module: booth_mult_arbiter

Interface
REQ-001 Parameter WIDTH, default 32, operand width in bits; product width is 2*WIDTH.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 req0_valid  input  1  requester 0 has an operation pending.
REQ-005 req0_ready  output  1  requester 0 operation accepted this cycle when high with req0_valid.
REQ-006 req0_a, req0_b  input  WIDTH each  requester 0 signed operands.
REQ-007 req1_valid, req1_ready, req1_a, req1_b  same widths and meaning for requester 1.
REQ-008 resp_valid  output  1  result available.
REQ-009 resp_ready  input  1  consumer accepts result.
REQ-010 resp_id  output  1  index of the requester that owns the result.
REQ-011 resp_product  output  2*WIDTH  signed product.
REQ-012 busy  output  1  high in any state other than IDLE.

Function
REQ-013 The block SHALL arbitrate two requesters onto one iterative radix-2 Booth multiplier with FSM states IDLE, ITER, DONE.
REQ-014 IDLE: grant = sole valid requester; if both valid, grant = requester not granted last (round-robin); reqN_ready SHALL be high only in IDLE and only for the granted N.
REQ-015 Accept (reqN_valid && reqN_ready) SHALL latch operands and N, clear the iteration counter, and go IDLE -> ITER; no accept when neither is valid.
REQ-016 Accumulator SHALL be WIDTH+1 bits, sign-extended, with multiplicand register WIDTH+1 bits, so the most negative operand multiplies correctly.
REQ-017 Each ITER cycle SHALL examine {Q[0], q_-1}: 01 add M, 10 subtract M, 00/11 no-op, then arithmetic-shift {A,Q,q_-1} right by one.
REQ-018 After exactly WIDTH ITER cycles the FSM SHALL go to DONE; resp_product = low 2*WIDTH bits of {A,Q}, resp_valid high.
REQ-019 Latency: accept at edge T -> resp_valid first high after edge T+WIDTH+1 (33 cycles for WIDTH=32).
REQ-020 In DONE, resp_valid, resp_id, resp_product SHALL hold stable until resp_ready is high; handshake returns FSM to IDLE on that edge.
REQ-021 After a response handshake, the next accept SHALL be possible on the following cycle; no request accepted in ITER or DONE.
REQ-022 Last-grant pointer SHALL update only on accept; requester whose valid drops before accept loses nothing.
REQ-023 resp_product SHALL equal the exact signed product for all operand pairs including min*min and max*min.

Reset
REQ-024 reset low SHALL immediately force IDLE, resp_valid=0, resp_id=0, resp_product=0, busy=0, both reqN_ready=0, last-grant=1 (requester 0 wins the first tie).
REQ-025 reset asserted mid-ITER or in DONE SHALL abort the operation with no response produced.
REQ-026 Operation SHALL resume on the first rising edge after reset returns high, with IDLE behaviour.

Verification
REQ-027 Reset, req0 -5*5 only -> req0_ready high same cycle; resp_valid exactly 33 cycles later, product 0xFFFFFFFFFFFFFFE7 (-25), resp_id=0.
REQ-028 Both valid from reset: req0 5*10, req1 -5*-20, resp_ready=1 -> 50 id0, then 100 id1; third tie -> id0 granted.
REQ-029 Corners: min*min -> 0x4000000000000000; max*min -> 0xC000000080000000; 0*0 -> 0; 1*50 -> 50.
REQ-030 Backpressure: 20*30, resp_ready low 10 cycles -> resp_valid, product 600, id stable; both reqN_ready low throughout; release -> IDLE next cycle.
REQ-031 Reset low at ITER cycle 10 of 30*-30 -> outputs zero asynchronously, no resp_valid; then 100*100 -> 10000 after 33 cycles.
REQ-032 Random: 1000 operations, random valids and resp_ready -> every product matches signed reference, ids match grant order, no starvation beyond one response.
